// File: rtl/coeff_bank.sv
`default_nettype none
// ============================================================================
// Module   : coeff_bank
// Purpose  : Coefficient storage for the polynomial evaluation datapath.
//            Holds one coefficient per segment (2^ADDR_LINES entries).
//            The bank is filled by a streaming write handshake and then read
//            through a one-cycle registered output.
// Ports    : clkn_i        - clock, all updates on the rising edge
//            rstn_i        - asynchronous active-low reset
//            load_start_i  - begin (re)load of the whole bank
//            wr_valid_i    - write word valid
//            wr_ready_o    - bank accepts a write word (LOAD state only)
//            wr_data_i     - coefficient word, streamed in address order
//            wr_last_i     - marks the final word of the load stream
//            rd_en_i       - read request
//            rd_ptr_i      - read address from the pointer counter
//            coeff_o       - registered read data
//            coeff_valid_o - one-cycle pulse per served read
//            bank_ready_o  - bank fully loaded and readable
//            load_err_o    - sticky, last load stream was malformed
//            par_err_o     - sticky parity error (COEFF_BANK_PARITY_EN only)
// Options  : COEFF_BANK_PARITY_EN - store an even-parity bit per entry and
//            check it on every read.
// Revision : 1.0 - initial release
// ============================================================================
module coeff_bank #(
  parameter int ADDR_LINES = 4,
  parameter int COEFF_W    = 16
) (
  input  logic                  clkn_i,
  input  logic                  rstn_i,
  input  logic                  load_start_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [COEFF_W-1:0]    wr_data_i,
  input  logic                  wr_last_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_LINES-1:0] rd_ptr_i,
  output logic [COEFF_W-1:0]    coeff_o,
  output logic                  coeff_valid_o,
  output logic                  bank_ready_o,
  output logic                  load_err_o
`ifdef COEFF_BANK_PARITY_EN
  ,
  output logic                  par_err_o
`endif
);

  localparam int DEPTH = 1 << ADDR_LINES;
`ifdef COEFF_BANK_PARITY_EN
  localparam int MEM_W = COEFF_W + 1;
`else
  localparam int MEM_W = COEFF_W;
`endif

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] READY = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_LINES-1:0] wr_idx_q, wr_idx_d;
  logic                  load_err_q, load_err_d;
  logic [COEFF_W-1:0]    coeff_q, coeff_d;
  logic                  coeff_valid_q, coeff_valid_d;

  // Storage is deliberately not reset; contents are only meaningful after a
  // complete load stream.
  logic [MEM_W-1:0]      mem_q [DEPTH];

  logic                  wr_fire;
  logic                  rd_fire;
  logic                  last_slot;
  logic [MEM_W-1:0]      wr_word;
  logic [MEM_W-1:0]      rd_word;

  assign wr_ready_o   = (state_q == LOAD);
  assign bank_ready_o = (state_q == READY);

  // A load restart wins over a same-cycle write, so the write is dropped.
  assign wr_fire   = wr_valid_i && wr_ready_o && !load_start_i;
  // Reads are served from the current contents even when a reload starts on
  // the same edge.
  assign rd_fire   = rd_en_i && bank_ready_o;
  assign last_slot = &wr_idx_q;

`ifdef COEFF_BANK_PARITY_EN
  // Even parity: the stored word including the parity bit has an even
  // number of ones.
  assign wr_word = {^wr_data_i, wr_data_i};
`else
  assign wr_word = wr_data_i;
`endif

  assign rd_word = mem_q[rd_ptr_i];

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    load_err_d = load_err_q;
    if (load_start_i) begin
      state_d    = LOAD;
      wr_idx_d   = '0;
      load_err_d = 1'b0;
    end else if (wr_fire) begin
      if (last_slot) begin
        // Final slot: the stream must end here; never wrap to entry 0.
        if (wr_last_i) begin
          state_d = READY;
        end else begin
          state_d    = IDLE;
          load_err_d = 1'b1;
        end
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
        if (wr_last_i) begin
          // Short stream: the word is kept but the bank stays unusable.
          state_d    = IDLE;
          load_err_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    coeff_valid_d = rd_fire;
    coeff_d       = rd_fire ? rd_word[COEFF_W-1:0] : coeff_q;
  end

  always_ff @(posedge clkn_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= IDLE;
      wr_idx_q      <= '0;
      load_err_q    <= 1'b0;
      coeff_q       <= '0;
      coeff_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      load_err_q    <= load_err_d;
      coeff_q       <= coeff_d;
      coeff_valid_q <= coeff_valid_d;
    end
  end

  always_ff @(posedge clkn_i) begin
    if (wr_fire) begin
      mem_q[wr_idx_q] <= wr_word;
    end
  end

  assign coeff_o       = coeff_q;
  assign coeff_valid_o = coeff_valid_q;
  assign load_err_o    = load_err_q;

`ifdef COEFF_BANK_PARITY_EN
  logic par_err_q, par_err_d;

  // A mismatch on a read served in the reload cycle is still reported, so
  // the set condition takes priority over the clear.
  always_comb begin
    par_err_d = par_err_q;
    if (rd_fire && (^rd_word)) begin
      par_err_d = 1'b1;
    end else if (load_start_i) begin
      par_err_d = 1'b0;
    end
  end

  always_ff @(posedge clkn_i or negedge rstn_i) begin
    if (!rstn_i) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err_o = par_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_coeff_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_coeff_bank
// Purpose  : Self-checking bench for coeff_bank. Read requests push their
//            expected coefficient into a queue; a monitor pops and compares
//            whenever coeff_valid_o is presented. Status outputs are checked
//            directly against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coeff_bank;

  logic        clk;
  logic        clk_en;
  logic        rstn;
  logic        load_start;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        wr_last;
  logic        rd_en;
  logic [3:0]  rd_ptr;
  logic [15:0] coeff;
  logic        coeff_valid;
  logic        bank_ready;
  logic        load_err;
`ifdef COEFF_BANK_PARITY_EN
  logic        par_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  coeff_bank #(.ADDR_LINES(4), .COEFF_W(16)) dut (
    .clkn_i       (clk),
    .rstn_i       (rstn),
    .load_start_i (load_start),
    .wr_valid_i   (wr_valid),
    .wr_ready_o   (wr_ready),
    .wr_data_i    (wr_data),
    .wr_last_i    (wr_last),
    .rd_en_i      (rd_en),
    .rd_ptr_i     (rd_ptr),
    .coeff_o      (coeff),
    .coeff_valid_o(coeff_valid),
    .bank_ready_o (bank_ready),
    .load_err_o   (load_err)
`ifdef COEFF_BANK_PARITY_EN
    ,
    .par_err_o    (par_err)
`endif
  );

  // Gated clock so the reset check can run with the clock idle.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rstn && coeff_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: coeff_o=%h valid with no read pending", coeff);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (coeff !== e) begin
          errors++;
          $display("FAIL rd_data: coeff_o=%h expected %h", coeff, e);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_load;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic stream(input logic [15:0] base, input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 16'(i);
      wr_last  = (i == last_at);
      tick();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic rd(input logic [3:0] ptr, input logic [15:0] expv);
    rd_en  = 1'b1;
    rd_ptr = ptr;
    exp_q.push_back(expv);
    tick();
    rd_en  = 1'b0;
  endtask

  initial begin
    clk_en     = 1'b1;
    rstn       = 1'b0;
    load_start = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    wr_last    = 1'b0;
    rd_en      = 1'b0;
    rd_ptr     = '0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // Reset state
    @(negedge clk);
    chk("rst_bank_ready", bank_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_coeff", coeff, 0);
    chk("rst_valid", coeff_valid, 0);

    // Full load
    start_load();
    @(negedge clk);
    chk("load_wr_ready", wr_ready, 1);
    stream(16'h0100, 15, -1);
    @(negedge clk);
    chk("load_not_ready_before_last", bank_ready, 0);
    stream(16'h010F, 1, 0);
    @(negedge clk);
    chk("load_bank_ready", bank_ready, 1);
    chk("load_no_err", load_err, 0);
    chk("load_wr_ready_off", wr_ready, 0);

    rd(4'd5, 16'h0105);
    @(negedge clk);
    @(negedge clk);
    chk("rd_valid_one_cycle", coeff_valid, 0);

    // Streaming reads
    rd_en = 1'b1;
    rd_ptr = 4'd0;  exp_q.push_back(16'h0100); tick();
    rd_ptr = 4'd15; exp_q.push_back(16'h010F); tick();
    rd_ptr = 4'd7;  exp_q.push_back(16'h0107); tick();
    rd_en = 1'b0;
    tick();
    @(negedge clk);
    chk("stream_valid_off", coeff_valid, 0);
    chk("stream_coeff_hold", coeff, 16'h0107);

    // Short stream
    start_load();
    stream(16'h0300, 4, 3);
    @(negedge clk);
    chk("short_load_err", load_err, 1);
    chk("short_bank_ready", bank_ready, 0);
    chk("short_idle", wr_ready, 0);
    rd_en = 1'b1; rd_ptr = 4'd1;
    tick();
    rd_en = 1'b0;
    @(negedge clk);
    chk("short_rd_ignored", coeff_valid, 0);
    chk("short_coeff_hold", coeff, 16'h0107);

    // Missing last flag on the final slot
    start_load();
    @(negedge clk);
    chk("restart_clears_err", load_err, 0);
    stream(16'h0400, 16, -1);
    @(negedge clk);
    chk("nolast_load_err", load_err, 1);
    chk("nolast_bank_ready", bank_ready, 0);
    chk("nolast_idle", wr_ready, 0);

    // Restart during a load drops the coincident write and rewinds the index
    start_load();
    stream(16'h0500, 2, -1);
    load_start = 1'b1; wr_valid = 1'b1; wr_data = 16'hDEAD;
    tick();
    load_start = 1'b0; wr_valid = 1'b0;
    stream(16'h0600, 16, 15);
    @(negedge clk);
    chk("prio_bank_ready", bank_ready, 1);
    rd(4'd0, 16'h0600);
    rd(4'd15, 16'h060F);

    // Reload collision with a read
    start_load();
    stream(16'h0100, 16, 15);
    rd_en = 1'b1; rd_ptr = 4'd2; load_start = 1'b1;
    exp_q.push_back(16'h0102);
    tick();
    rd_en = 1'b0; load_start = 1'b0;
    @(negedge clk);
    chk("coll_bank_ready_drop", bank_ready, 0);
    chk("coll_in_load", wr_ready, 1);
    stream(16'h0200, 16, 15);
    rd(4'd2, 16'h0202);

`ifdef COEFF_BANK_PARITY_EN
    dut.mem_q[9] = dut.mem_q[9] ^ 17'h00001;
    @(negedge clk);
    chk("par_clean", par_err, 0);
    rd(4'd9, 16'h0208);
    @(negedge clk);
    chk("par_err_set", par_err, 1);
    start_load();
    @(negedge clk);
    chk("par_err_clear", par_err, 0);
    start_load();
    stream(16'h0200, 16, 15);
`endif

    // Asynchronous reset with the clock stopped
    tick();
    @(negedge clk);
    clk_en = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("async_coeff", coeff, 0);
    chk("async_valid", coeff_valid, 0);
    chk("async_bank_ready", bank_ready, 0);
    chk("async_wr_ready", wr_ready, 0);
    chk("async_load_err", load_err, 0);
    #1 rstn = 1'b1;
    clk_en = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_bank_ready", bank_ready, 0);
    chk("post_rst_wr_ready", wr_ready, 0);

    repeat (2) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/coeff_bank.md
Name: coeff_bank

Overview:
- Coefficient storage stage directly downstream of the coefficient read-pointer counter.
- Holds one polynomial coefficient per segment, 2^ADDR_LINES entries.
- Loaded once by a streaming write handshake, then read by the segment pointer with a registered output.
- Feeds coeff_o/coeff_valid_o into the polynomial evaluation datapath of the non-linear approximation engine.

Parameters:
- ADDR_LINES, 4, pointer width; DEPTH = 1 << ADDR_LINES entries.
- COEFF_W, 16, coefficient word width in bits.

Ports:
- clkn_i  in  1  clock; all state updates on posedge.
- rstn_i  in  1  asynchronous active-low reset.
- load_start_i  in  1  begin (re)load of the whole bank.
- wr_valid_i  in  1  write word valid.
- wr_ready_o  out  1  bank accepts a write word.
- wr_data_i  in  COEFF_W  coefficient word, written in address order 0..DEPTH-1.
- wr_last_i  in  1  marks final word of the load stream.
- rd_en_i  in  1  read request.
- rd_ptr_i  in  ADDR_LINES  read address, from the pointer counter.
- coeff_o  out  COEFF_W  registered read data.
- coeff_valid_o  out  1  coeff_o updated this cycle (1-cycle pulse per read).
- bank_ready_o  out  1  bank fully loaded and readable.
- load_err_o  out  1  sticky; last load stream was malformed.

Behaviour:
- Reset (rstn_i low, asynchronous): state IDLE, wr_idx=0, wr_ready_o=0, coeff_o=0, coeff_valid_o=0, bank_ready_o=0, load_err_o=0. Memory array is not reset.
- FSM states: IDLE, LOAD, READY.
- load_start_i in any state: next state LOAD, wr_idx=0, bank_ready_o=0, load_err_o cleared.
- load_start_i has priority over any write in the same cycle; that write is dropped.
- wr_ready_o = 1 only in LOAD. A write fires when wr_valid_i && wr_ready_o; mem[wr_idx] <= wr_data_i, then wr_idx+1.
- Write at wr_idx==DEPTH-1 with wr_last_i=1: next state READY, bank_ready_o=1.
- Write at wr_idx==DEPTH-1 with wr_last_i=0: error. load_err_o=1, next state IDLE, no wrap-around.
- Write at wr_idx<DEPTH-1 with wr_last_i=1 (short stream): word is still written, then load_err_o=1, next state IDLE.
- In IDLE, wr_valid_i is ignored.
- Read: when rd_en_i && bank_ready_o at edge N, coeff_o = mem[rd_ptr_i] and coeff_valid_o=1 after edge N. Latency is 1 cycle; back-to-back reads give one word per cycle.
- Reads while bank_ready_o=0 are ignored: coeff_valid_o=0, coeff_o holds its value.
- coeff_o holds its last value whenever coeff_valid_o=0.
- rd_en_i and load_start_i together in READY: the read is served with pre-load contents and valid pulses; bank_ready_o drops on the same edge.
- rd_ptr_i is sampled only when a read fires; any value 0..DEPTH-1 is legal.

Optional Feature:
- Macro COEFF_BANK_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed on write.
  - Each read recomputes parity over the stored word.
  - A mismatch sets output par_err_o (1 bit, sticky, reset 0, cleared by load_start_i) in the same cycle coeff_valid_o pulses.
  - Data is still delivered.
- Undefined: no parity storage, no par_err_o port; array width is COEFF_W.

Test Plan:
- Reset: assert rstn_i mid-cycle with clock idle -> all outputs 0 immediately; after release, bank_ready_o=0, wr_ready_o=0.
- Full load: load_start_i pulse, 16 writes of 0x0100+i with wr_last_i on i=15 -> bank_ready_o=1 the cycle after the last write, load_err_o=0; rd_ptr_i=5, rd_en_i=1 -> next cycle coeff_o=0x0105, coeff_valid_o=1 for one cycle.
- Streaming reads: rd_ptr_i = 0,15,7 on consecutive cycles with rd_en_i held high -> coeff_o = 0x0100, 0x010F, 0x0107 on consecutive cycles, valid high for 3 cycles.
- Short stream: load with wr_last_i on i=3 -> load_err_o=1, state IDLE, bank_ready_o=0; rd_en_i=1 -> coeff_valid_o stays 0.
- Reload collision: in READY, load_start_i and rd_en_i with rd_ptr_i=2 together -> coeff_o=0x0102 valid; bank_ready_o=0 next cycle. Reload with 0x0200+i -> read of ptr 2 returns 0x0202.
- Parity (COEFF_BANK_PARITY_EN): after a full load, force-flip one data bit of entry 9, then read ptr 9 -> par_err_o=1 with coeff_valid_o; load_start_i clears it.
